// File: rtl/fifo_rr_scheduler_if.sv
// Handshake bundle between the per-channel FIFO bank, the round-robin
// scheduler and the shared downstream FIFO.
interface fifo_rr_scheduler_if #(
    parameter int unsigned DATA_SIZE = 6,
    parameter int unsigned NUM_Q     = 4
);
    logic [NUM_Q-1:0]           q_empty;
    logic [NUM_Q*DATA_SIZE-1:0] q_data;
    logic [NUM_Q-1:0]           q_read;
    logic                       ds_pause;
    logic                       ds_full;
    logic                       ds_write;
    logic [DATA_SIZE-1:0]       ds_data;

    modport master (
        input  q_empty, q_data, ds_pause, ds_full,
        output q_read, ds_write, ds_data
    );

    modport slave (
        output q_empty, q_data, ds_pause, ds_full,
        input  q_read, ds_write, ds_data
    );
endinterface

// File: rtl/fifo_rr_scheduler.sv
// Round-robin drain of NUM_Q input FIFOs into one downstream FIFO:
// pop (cycle t) -> capture (t+1) -> push (t+2), throttled by ds_pause.
module fifo_rr_scheduler #(
    parameter int unsigned DATA_SIZE = 6,
    parameter int unsigned NUM_Q     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    fifo_rr_scheduler_if.master  bus,
    output logic [2:0]           grant_id,
    output logic                 idle,
    output logic                 ovf_error
);

    localparam int unsigned PTR_W = (NUM_Q > 1) ? $clog2(NUM_Q) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    state_t               state, state_n;
    logic [PTR_W-1:0]     rr_ptr, rr_ptr_n;
    logic [PTR_W-1:0]     pick_idx, cand;
    logic                 pick_valid;
    logic [PTR_W-1:0]     sel_r, cap_sel;
    logic [NUM_Q-1:0]     elig_c, q_read_r, q_read_n;
    logic                 any_elig, all_empty;
    logic                 grant_en;
    logic                 cap_valid;
    logic                 ds_write_r;
    logic [DATA_SIZE-1:0] ds_data_r;
    logic                 idle_n;
    logic [DATA_SIZE-1:0] q_words [NUM_Q];

    for (genvar g = 0; g < NUM_Q; g++) begin : g_unpack
        assign q_words[g] = bus.q_data[g*DATA_SIZE +: DATA_SIZE];
    end

    // Empty flags lag a pop by one cycle, so the queue being popped now is excluded.
    assign elig_c    = ~bus.q_empty & ~q_read_r;
    assign any_elig  = |elig_c;
    assign all_empty = &bus.q_empty;

    // First eligible queue at or after the round-robin pointer.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 0; k < NUM_Q; k++) begin
            cand = PTR_W'((32'(rr_ptr) + 32'(k)) % NUM_Q);
            if (!pick_valid && elig_c[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        state_n  = state;
        q_read_n = '0;
        rr_ptr_n = rr_ptr;
        case (state)
            S_IDLE: begin
                if (enable && any_elig && !bus.ds_pause) state_n = S_RUN;
            end
            S_RUN: begin
                if (!enable)           state_n = S_IDLE;
                else if (bus.ds_pause) state_n = S_PAUSE;
                else if (all_empty)    state_n = S_IDLE;
            end
            S_PAUSE: begin
                if (!enable)            state_n = S_IDLE;
                else if (!bus.ds_pause) state_n = any_elig ? S_RUN : S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase

        // A grant is issued in the same cycle the decision to run is made.
        grant_en = (state_n == S_RUN) && pick_valid;
        if (grant_en) begin
            q_read_n[pick_idx] = 1'b1;
            rr_ptr_n           = PTR_W'((32'(pick_idx) + 32'd1) % NUM_Q);
        end

        idle_n = (state_n != S_RUN) && (q_read_r == '0) && !cap_valid;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            rr_ptr     <= '0;
            q_read_r   <= '0;
            grant_id   <= 3'd0;
            sel_r      <= '0;
            cap_valid  <= 1'b0;
            cap_sel    <= '0;
            ds_write_r <= 1'b0;
            ds_data_r  <= '0;
            idle       <= 1'b1;
            ovf_error  <= 1'b0;
        end else begin
            state     <= state_n;
            rr_ptr    <= rr_ptr_n;
            q_read_r  <= q_read_n;
            idle      <= idle_n;
            if (grant_en) begin
                grant_id <= 3'(pick_idx);
                sel_r    <= pick_idx;
            end
            // Popped word shows up on q_data one cycle after the strobe.
            cap_valid <= |q_read_r;
            if (|q_read_r) cap_sel <= sel_r;
            ds_write_r <= cap_valid;
            if (cap_valid) ds_data_r <= q_words[cap_sel];
            if (ds_write_r && bus.ds_full) ovf_error <= 1'b1;
        end
    end

    assign bus.q_read   = q_read_r;
    assign bus.ds_write = ds_write_r;
    assign bus.ds_data  = ds_data_r;

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// Self-checking bench: FIFO-bank model plus a queue-level reference of the scheduler.
module tb_fifo_rr_scheduler;

    localparam int DS = 6;
    localparam int NQ = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [2:0] grant_id;
    logic       idle;
    logic       ovf_error;

    fifo_rr_scheduler_if #(.DATA_SIZE(DS), .NUM_Q(NQ)) bus ();

    fifo_rr_scheduler #(.DATA_SIZE(DS), .NUM_Q(NQ)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .bus       (bus),
        .grant_id  (grant_id),
        .idle      (idle),
        .ovf_error (ovf_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [DS-1:0] d;
    } push_t;

    typedef struct {
        bit          en;
        bit          pause;
        bit          full;
        logic [NQ-1:0] qr;
        bit          w;
        logic [DS-1:0] d;
        bit          idl;
    } vec_t;

    logic [DS-1:0] fifo [NQ][$];
    logic [DS-1:0] dout [NQ];
    push_t         pend [$];
    vec_t          tbl  [$];

    int            n_err = 0;
    int            n_chk = 0;
    int            cyc   = 0;
    logic [NQ-1:0] exp_qread = '0;
    logic [2:0]    exp_gid   = 3'd0;
    int            mptr      = 0;
    bit            exp_ovf   = 1'b0;
    bit            cur_w     = 1'b0;
    logic [DS-1:0] cur_d     = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic refresh_if();
        for (int i = 0; i < NQ; i++) begin
            bus.q_empty[i]           = (fifo[i].size() == 0);
            bus.q_data[i*DS +: DS]   = dout[i];
        end
    endtask

    // One clock: predict from the rules, advance, emulate FIFO pops, compare.
    task automatic tick();
        logic [NQ-1:0] nxt;
        logic [NQ-1:0] pops;
        logic [2:0]    gid;
        bit            ovf_n;
        int            j;
        push_t         p;
        nxt   = '0;
        gid   = exp_gid;
        ovf_n = exp_ovf;
        if (enable && !bus.ds_pause) begin
            for (int k = 0; k < NQ; k++) begin
                j = (mptr + k) % NQ;
                if (nxt == '0 && fifo[j].size() > 0 && !exp_qread[j]) begin
                    nxt[j] = 1'b1;
                    gid    = 3'(j);
                    p.due  = cyc + 3;
                    p.d    = fifo[j][0];
                    pend.push_back(p);
                    mptr   = (j + 1) % NQ;
                end
            end
        end
        if (cur_w && bus.ds_full) ovf_n = 1'b1;
        pops = bus.q_read;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < NQ; i++)
            if (pops[i] && fifo[i].size() > 0) dout[i] = fifo[i].pop_front();
        refresh_if();
        exp_qread = nxt;
        exp_gid   = gid;
        exp_ovf   = ovf_n;
        cur_w     = 1'b0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            p     = pend.pop_front();
            cur_w = 1'b1;
            cur_d = p.d;
        end
        chk("q_read", 32'(bus.q_read), 32'(exp_qread));
        chk("ds_write", 32'(bus.ds_write), 32'(cur_w));
        if (cur_w) chk("ds_data", 32'(bus.ds_data), 32'(cur_d));
        if (exp_qread != '0) chk("grant_id", 32'(grant_id), 32'(exp_gid));
        chk("ovf_error", 32'(ovf_error), 32'(exp_ovf));
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        pend.delete();
        exp_qread = '0;
        exp_gid   = 3'd0;
        mptr      = 0;
        exp_ovf   = 1'b0;
        cur_w     = 1'b0;
        refresh_if();
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("rst_q_read", 32'(bus.q_read), 32'd0);
        chk("rst_ds_write", 32'(bus.ds_write), 32'd0);
        chk("rst_ds_data", 32'(bus.ds_data), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        chk("rst_idle", 32'(idle), 32'd1);
        chk("rst_ovf", 32'(ovf_error), 32'd0);
        reset = 1'b0;
    endtask

    task automatic run_tbl(input string nm);
        for (int r = 0; r < tbl.size(); r++) begin
            enable       = tbl[r].en;
            bus.ds_pause = tbl[r].pause;
            bus.ds_full  = tbl[r].full;
            tick();
            chk({nm, "_q_read"}, 32'(bus.q_read), 32'(tbl[r].qr));
            chk({nm, "_ds_write"}, 32'(bus.ds_write), 32'(tbl[r].w));
            if (tbl[r].w) chk({nm, "_ds_data"}, 32'(bus.ds_data), 32'(tbl[r].d));
            chk({nm, "_idle"}, 32'(idle), 32'(tbl[r].idl));
        end
        tbl.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
        $fatal(1);
    end

    initial begin
        int wcnt;
        for (int i = 0; i < NQ; i++) dout[i] = '0;
        bus.ds_pause = 1'b0;
        bus.ds_full  = 1'b0;
        refresh_if();
        do_reset(3);

        // All queues empty: nothing may move.
        enable = 1'b1;
        repeat (10) begin
            tick();
            chk("empty_idle", 32'(idle), 32'd1);
        end

        // One word in each queue.
        for (int i = 0; i < NQ; i++) fifo[i].push_back(DS'(3 + i));
        refresh_if();
        tbl.push_back('{1'b1, 1'b0, 1'b0, 4'b0001, 1'b0, 6'h00, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 4'b0010, 1'b0, 6'h00, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 4'b0100, 1'b1, 6'h03, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 4'b1000, 1'b1, 6'h04, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 6'h05, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 6'h06, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 6'h00, 1'b1});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 6'h00, 1'b1});
        run_tbl("four_q");

        // Single active queue drains every other cycle.
        fifo[2].push_back(6'h0A);
        fifo[2].push_back(6'h0B);
        fifo[2].push_back(6'h0C);
        refresh_if();
        tbl.push_back('{1'b1, 1'b0, 1'b0, 4'b0100, 1'b0, 6'h00, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 6'h00, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 4'b0100, 1'b1, 6'h0A, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 6'h00, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 4'b0100, 1'b1, 6'h0B, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 6'h00, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 6'h0C, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 6'h00, 1'b1});
        run_tbl("one_q");

        // Continuous traffic with a 4-cycle pause window.
        wcnt = 0;
        for (int t = 0; t < 16; t++) begin
            for (int i = 0; i < NQ; i++)
                while (fifo[i].size() < 2) fifo[i].push_back(DS'($urandom));
            refresh_if();
            bus.ds_pause = (t >= 5 && t <= 8);
            tick();
            if (t >= 5 && t <= 8) begin
                if (bus.ds_write) wcnt++;
                chk("pause_no_pop", 32'(bus.q_read), 32'd0);
            end
            if (t == 9) chk("pause_resume", 32'(bus.q_read != '0), 32'd1);
        end
        chk("pause_writes_le2", 32'(wcnt <= 2), 32'd1);
        bus.ds_pause = 1'b0;
        repeat (25) tick();
        chk("drained_idle", 32'(idle), 32'd1);

        // Push into a full downstream FIFO sets the sticky overflow flag.
        fifo[0].push_back(6'h15);
        refresh_if();
        bus.ds_full = 1'b1;
        repeat (5) tick();
        bus.ds_full = 1'b0;
        repeat (3) tick();
        chk("ovf_sticky", 32'(ovf_error), 32'd1);
        do_reset(2);

        // Reset one cycle after the first pop: in-flight words are lost.
        for (int i = 0; i < NQ; i++) fifo[i].push_back(DS'(6'h20 + i));
        refresh_if();
        tick();
        chk("midrst_first", 32'(bus.q_read), 32'b0001);
        tick();
        reset = 1'b1;
        #1;
        chk("midrst_async_q_read", 32'(bus.q_read), 32'd0);
        chk("midrst_async_ds_write", 32'(bus.ds_write), 32'd0);
        chk("midrst_async_idle", 32'(idle), 32'd1);
        fifo[0].push_back(6'h30);
        do_reset(2);
        tick();
        chk("midrst_restart_q0", 32'(bus.q_read), 32'b0001);
        chk("midrst_no_write_a", 32'(bus.ds_write), 32'd0);
        tick();
        chk("midrst_no_write_b", 32'(bus.ds_write), 32'd0);
        repeat (15) tick();

        // Randomized traffic against the reference model.
        for (int t = 0; t < 400; t++) begin
            for (int i = 0; i < NQ; i++)
                if ($urandom_range(0, 2) == 0 && fifo[i].size() < 4)
                    fifo[i].push_back(DS'($urandom));
            refresh_if();
            enable       = ($urandom_range(0, 9) != 0);
            bus.ds_pause = ($urandom_range(0, 6) == 0);
            tick();
        end
        enable       = 1'b1;
        bus.ds_pause = 1'b0;
        repeat (30) tick();
        chk("final_idle", 32'(idle), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
